roachf_1024_bao_loopback_ctrl: RTL and testbench

OPB-mapped sequencer for the loopback test path: software programs a loop count and timeout, writes start, and the block issues one transmit pulse per loop, waits for the receive-done strobe, and counts completed and errored loops. It sits on the PPC OPB bus beside the loopback status registers. All counters and status are readable over OPB.

---
 rtl/roachf_1024_bao_loopback_ctrl_if.sv | 25 ++
 rtl/roachf_1024_bao_loopback_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_roachf_1024_bao_loopback_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/roachf_1024_bao_loopback_ctrl_if.sv
// OPB slave-side bus bundle for the loopback sequencer.
// Bit 0 of each bus is the MSB, as on the PPC OPB.
interface roachf_1024_bao_loopback_ctrl_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/roachf_1024_bao_loopback_ctrl.sv
// OPB-mapped loopback sequencer: issues one tx pulse per loop, waits for rx_done,
// counts completed and errored loops, with an optional per-loop timeout.
module roachf_1024_bao_loopback_ctrl #(
  parameter logic [31:0] C_BASEADDR   = 32'h01014000,
  parameter logic [31:0] C_HIGHADDR   = 32'h010140FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                                  OPB_Clk,
  input  logic                                  OPB_Rst,
  roachf_1024_bao_loopback_ctrl_if.slave        opb,
  output logic                                  lb_tx_start,
  input  logic                                  lb_rx_done,
  input  logic                                  lb_rx_err,
  output logic                                  lb_busy
);

  typedef enum logic [1:0] {StIdle, StArm, StWait} state_e;

  state_e state_q, state_d;

  logic [C_OPB_AWIDTH-1:0] addr, offset;
  logic [C_OPB_DWIDTH-1:0] wdata;
  logic [3:0]  be;
  logic [5:0]  word;
  logic        hit, ack_q, wr_en;
  logic [31:0] rdata_q, rd_val;
  logic        sel_ctrl, sel_num, sel_tout;
  logic        start_wr, abort_wr;

  logic [31:0] num_loops_q, run_n_q, loop_cnt_q, err_cnt_q;
  logic [31:0] loop_inc, err_inc, num_merged, tout_merged;
  logic [15:0] timeout_q, timer_q;
  logic        done_q, tout_q;
  logic        loop_last, timeout_hit;

  // Byte lane i of the numeric value is enabled by en[i] (en[3] is OPB_BE[0]).
  function automatic logic [31:0] be_merge(logic [31:0] old, logic [31:0] nw, logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) r[8*i +: 8] = nw[8*i +: 8];
    end
    return r;
  endfunction

  assign addr   = opb.OPB_ABus;
  assign offset = addr - C_BASEADDR;
  assign word   = offset[7:2];
  assign wdata  = opb.OPB_DBus;
  assign be     = opb.OPB_BE;
  assign hit    = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign wr_en  = ack_q && hit && !opb.OPB_RNW;

  assign sel_ctrl = (word == 6'h00);
  assign sel_num  = (word == 6'h01);
  assign sel_tout = (word == 6'h04);

  // Abort takes priority over start when both bits are written together.
  assign abort_wr = wr_en && sel_ctrl && be[0] && wdata[1];
  assign start_wr = wr_en && sel_ctrl && be[0] && wdata[0] && !wdata[1];

  assign num_merged  = be_merge(num_loops_q, wdata, be);
  assign tout_merged = be_merge({16'h0000, timeout_q}, wdata, be);

  assign loop_inc    = (loop_cnt_q == 32'hFFFF_FFFF) ? loop_cnt_q : loop_cnt_q + 32'd1;
  assign err_inc     = (err_cnt_q == 32'hFFFF_FFFF) ? err_cnt_q : err_cnt_q + 32'd1;
  assign loop_last   = (loop_inc == run_n_q);
  assign timeout_hit = (timeout_q != 16'h0000) && (timer_q == timeout_q - 16'd1);

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_wr) state_d = (num_loops_q == 32'd0) ? StIdle : StArm;
      end
      StArm: begin
        state_d = abort_wr ? StIdle : StWait;
      end
      StWait: begin
        if (abort_wr) begin
          state_d = StIdle;
        end else if (lb_rx_done) begin
          state_d = loop_last ? StIdle : StArm;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    lb_tx_start = 1'b0;
    lb_busy     = 1'b1;
    unique case (state_q)
      StIdle:  lb_busy = 1'b0;
      StArm:   lb_tx_start = 1'b1;
      StWait:  lb_busy = 1'b1;
      default: lb_busy = 1'b0;
    endcase
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      num_loops_q <= 32'd0;
      run_n_q     <= 32'd0;
      loop_cnt_q  <= 32'd0;
      err_cnt_q   <= 32'd0;
      timeout_q   <= 16'hFFFF;
      timer_q     <= 16'd0;
      done_q      <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      if (wr_en && sel_num)  num_loops_q <= num_merged;
      if (wr_en && sel_tout) timeout_q   <= tout_merged[15:0];
      unique case (state_q)
        StIdle: begin
          if (start_wr) begin
            loop_cnt_q <= 32'd0;
            err_cnt_q  <= 32'd0;
            tout_q     <= 1'b0;
            done_q     <= (num_loops_q == 32'd0);
            run_n_q    <= num_loops_q;
          end
        end
        StArm: timer_q <= 16'd0;
        StWait: begin
          if (!abort_wr) begin
            if (lb_rx_done) begin
              loop_cnt_q <= loop_inc;
              if (lb_rx_err) err_cnt_q <= err_inc;
              if (loop_last) done_q <= 1'b1;
            end else if (timeout_hit) begin
              tout_q <= 1'b1;
            end else begin
              timer_q <= timer_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = 32'd0;
    case (word)
      6'h00:   rd_val = {29'd0, tout_q, done_q, lb_busy};
      6'h01:   rd_val = num_loops_q;
      6'h02:   rd_val = loop_cnt_q;
      6'h03:   rd_val = err_cnt_q;
      6'h04:   rd_val = {16'd0, timeout_q};
      default: rd_val = 32'd0;
    endcase
  end

  // Ack and read data are registered; suppressing a back-to-back ack gives 2-cycle accesses.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ack_q   <= hit && !ack_q;
      rdata_q <= (hit && !ack_q && opb.OPB_RNW) ? rd_val : 32'd0;
    end
  end

  assign opb.Sl_DBus    = rdata_q;
  assign opb.Sl_xferAck = ack_q;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{offset[31:8], offset[1:0], tout_merged[31:16], opb.OPB_seqAddr};

endmodule

// File: tb/tb_roachf_1024_bao_loopback_ctrl.sv
// Bench for the loopback sequencer: register vectors, directed run sequences and
// randomized runs checked against a loop-level reference model.
module tb_roachf_1024_bao_loopback_ctrl;
  localparam logic [31:0] Base = 32'h01014000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lb_tx_start, lb_busy;
  logic lb_rx_done = 1'b0;
  logic lb_rx_err  = 1'b0;

  roachf_1024_bao_loopback_ctrl_if bus();

  roachf_1024_bao_loopback_ctrl dut (
    .OPB_Clk     (clk),
    .OPB_Rst     (rst),
    .opb         (bus),
    .lb_tx_start (lb_tx_start),
    .lb_rx_done  (lb_rx_done),
    .lb_rx_err   (lb_rx_err),
    .lb_busy     (lb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_wr;
    logic [31:0] off;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int tx_count = 0;
  bit tx_prev = 1'b0;
  int dly_tab[8];
  bit err_tab[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Counts tx pulses and flags any pulse longer than one cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (lb_tx_start) begin
        tx_count++;
        check("tx_pulse_width", {31'd0, tx_prev}, 32'd0);
      end
      tx_prev = lb_tx_start;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [31:0] off, input logic rnw, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] rdata);
    int n;
    @(negedge clk);
    bus.OPB_ABus   = Base + off;
    bus.OPB_RNW    = rnw;
    bus.OPB_DBus   = rnw ? 32'd0 : wdata;
    bus.OPB_BE     = be;
    bus.OPB_select = 1'b1;
    n = 0;
    step();
    while (!bus.Sl_xferAck && n < 8) begin
      step();
      n++;
    end
    check("ack_latency", n, 0);
    rdata = bus.Sl_DBus;
    step();
    check("ack_width", {31'd0, bus.Sl_xferAck}, 32'd0);
    check("dbus_idle", bus.Sl_DBus, 32'd0);
    bus.OPB_select = 1'b0;
    bus.OPB_RNW    = 1'b0;
    bus.OPB_DBus   = 32'd0;
    bus.OPB_BE     = 4'b0000;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    xfer(off, 1'b0, d, 4'b1111, dummy);
  endtask

  task automatic rd_check(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] r;
    xfer(off, 1'b1, 32'd0, 4'b1111, r);
    check(name, r, exp);
  endtask

  task automatic wait_tx(output bit found);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (lb_tx_start) begin
        found = 1'b1;
        return;
      end
      step();
    end
    check("tx_wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (lb_busy && n < 300) begin
      step();
      n++;
    end
    check("idle_wait", {31'd0, lb_busy}, 32'd0);
  endtask

  task automatic pulse_rx(input bit err);
    lb_rx_done = 1'b1;
    lb_rx_err  = err;
    step();
    lb_rx_done = 1'b0;
    lb_rx_err  = 1'b0;
  endtask

  // Runs n loops answering loop i after dly_tab[i] cycles; loops whose delay exceeds a
  // nonzero timeout are left unanswered. Results compared with a loop-level model.
  task automatic do_run(input int n, input int t);
    int tx0, exp_loops, exp_err, exp_tx;
    bit exp_done, exp_to, found;
    wr(32'h10, t);
    wr(32'h04, n);
    tx0 = tx_count;
    wr(32'h00, 32'h1);
    for (int i = 0; i < n; i++) begin
      wait_tx(found);
      if (!found) break;
      if (t != 0 && dly_tab[i] > t) break;
      repeat (dly_tab[i]) step();
      pulse_rx(err_tab[i]);
    end
    wait_idle();
    exp_loops = 0;
    exp_err   = 0;
    exp_tx    = 0;
    exp_to    = 1'b0;
    exp_done  = (n == 0);
    for (int i = 0; i < n; i++) begin
      exp_tx++;
      if (t != 0 && dly_tab[i] > t) begin
        exp_to = 1'b1;
        break;
      end
      exp_loops++;
      exp_err += int'(err_tab[i]);
      if (exp_loops == n) exp_done = 1'b1;
    end
    step();
    check("run_tx_count", tx_count - tx0, exp_tx);
    rd_check("run_loop_cnt", 32'h08, exp_loops);
    rd_check("run_err_cnt", 32'h0C, exp_err);
    rd_check("run_ctrl", 32'h00, {29'd0, exp_to, exp_done, 1'b0});
  endtask

  vec_t vtab[13];
  bit found;
  int tx0, n;

  initial begin
    bus.OPB_ABus    = 32'd0;
    bus.OPB_BE      = 4'b0000;
    bus.OPB_DBus    = 32'd0;
    bus.OPB_RNW     = 1'b0;
    bus.OPB_select  = 1'b0;
    bus.OPB_seqAddr = 1'b0;

    vtab[0]  = '{1'b0, 32'h00, 32'h0, 4'b0000, 32'h0000_0000};
    vtab[1]  = '{1'b0, 32'h04, 32'h0, 4'b0000, 32'h0000_0000};
    vtab[2]  = '{1'b0, 32'h08, 32'h0, 4'b0000, 32'h0000_0000};
    vtab[3]  = '{1'b0, 32'h0C, 32'h0, 4'b0000, 32'h0000_0000};
    vtab[4]  = '{1'b0, 32'h10, 32'h0, 4'b0000, 32'h0000_FFFF};
    vtab[5]  = '{1'b1, 32'h04, 32'h1122_3344, 4'b0101, 32'h0022_0044};
    vtab[6]  = '{1'b1, 32'h04, 32'hFFFF_FFFF, 4'b1000, 32'hFF22_0044};
    vtab[7]  = '{1'b1, 32'h10, 32'hABCD_1234, 4'b1111, 32'h0000_1234};
    vtab[8]  = '{1'b1, 32'h10, 32'h0000_FF00, 4'b0010, 32'h0000_FF34};
    vtab[9]  = '{1'b1, 32'h08, 32'h1234_5678, 4'b1111, 32'h0000_0000};
    vtab[10] = '{1'b1, 32'h0C, 32'h1234_5678, 4'b1111, 32'h0000_0000};
    vtab[11] = '{1'b1, 32'h20, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000};
    vtab[12] = '{1'b1, 32'h00, 32'h0000_0001, 4'b0000, 32'h0000_0000};

    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_start", {31'd0, lb_tx_start}, 32'd0);
    check("rst_busy", {31'd0, lb_busy}, 32'd0);
    check("rst_ack", {31'd0, bus.Sl_xferAck}, 32'd0);
    check("rst_dbus", bus.Sl_DBus, 32'd0);
    check("const_outs", {29'd0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      logic [31:0] r;
      if (vtab[i].do_wr) xfer(vtab[i].off, 1'b0, vtab[i].wdata, vtab[i].be, r);
      xfer(vtab[i].off, 1'b1, 32'd0, 4'b1111, r);
      check($sformatf("vec%0d_off%02h", i, vtab[i].off), r, vtab[i].exp);
    end

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Three loops answered after 5 cycles, second one errored.
    for (int i = 0; i < 8; i++) begin
      dly_tab[i] = 5;
      err_tab[i] = (i == 1);
    end
    do_run(3, 32'hFFFF);

    // Timeout of 10 with no response: busy drops exactly 10 cycles after WAIT entry.
    wr(32'h10, 32'd10);
    wr(32'h04, 32'd2);
    tx0 = tx_count;
    wr(32'h00, 32'h1);
    check("start_tx_timing", {30'd0, lb_tx_start, lb_busy}, 32'd3);
    n = 0;
    while (lb_busy && n < 50) begin
      step();
      n++;
    end
    check("timeout_cycles", n, 11);
    check("timeout_tx_count", tx_count - tx0, 1);
    rd_check("timeout_ctrl", 32'h00, 32'h4);
    rd_check("timeout_loop_cnt", 32'h08, 32'h0);

    // Zero loops: done straight away, no pulse.
    wr(32'h10, 32'hFFFF);
    wr(32'h04, 32'd0);
    tx0 = tx_count;
    wr(32'h00, 32'h1);
    check("zero_busy", {30'd0, lb_tx_start, lb_busy}, 32'd0);
    rd_check("zero_ctrl", 32'h00, 32'h2);
    check("zero_tx_count", tx_count - tx0, 0);

    // Abort after four of one hundred loops.
    wr(32'h04, 32'd100);
    tx0 = tx_count;
    wr(32'h00, 32'h1);
    for (int i = 0; i < 4; i++) begin
      wait_tx(found);
      repeat (3) step();
      pulse_rx(1'b0);
    end
    wait_tx(found);
    wr(32'h00, 32'h3);
    check("abort_busy", {31'd0, lb_busy}, 32'd0);
    rd_check("abort_loop_cnt", 32'h08, 32'd4);
    rd_check("abort_ctrl", 32'h00, 32'h0);
    check("abort_tx_count", tx_count - tx0, 5);

    // rx_done on the timeout cycle counts the loop.
    dly_tab[0] = 4;
    err_tab[0] = 1'b0;
    do_run(1, 4);

    pulse_rx(1'b1);
    repeat (2) step();
    rd_check("idle_rx_loop_cnt", 32'h08, 32'd1);
    rd_check("idle_rx_err_cnt", 32'h0C, 32'd0);

    // Start and NUM_LOOPS writes during a run leave it untouched.
    wr(32'h10, 32'd0);
    wr(32'h04, 32'd2);
    tx0 = tx_count;
    wr(32'h00, 32'h1);
    wr(32'h00, 32'h1);
    wr(32'h04, 32'd7);
    check("busy_mid_run", {31'd0, lb_busy}, 32'd1);
    pulse_rx(1'b0);
    wait_tx(found);
    step();
    pulse_rx(1'b1);
    wait_idle();
    check("busy_start_tx_count", tx_count - tx0, 2);
    rd_check("busy_start_loop_cnt", 32'h08, 32'd2);
    rd_check("busy_start_err_cnt", 32'h0C, 32'd1);
    rd_check("busy_start_num_loops", 32'h04, 32'd7);
    rd_check("busy_start_ctrl", 32'h00, 32'h2);

    // Randomized runs against the loop-level model.
    for (int it = 0; it < 12; it++) begin
      int nl, t;
      nl = $urandom_range(1, 5);
      t  = $urandom_range(0, 12);
      for (int i = 0; i < 8; i++) begin
        dly_tab[i] = $urandom_range(1, 14);
        err_tab[i] = 1'($urandom_range(0, 1));
      end
      do_run(nl, t);
    end

    // Asynchronous reset mid-run.
    wr(32'h10, 32'd0);
    wr(32'h04, 32'd5);
    tx0 = tx_count;
    wr(32'h00, 32'h1);
    wait_tx(found);
    repeat (2) step();
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {30'd0, lb_tx_start, lb_busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();
    check("rst_mid_tx_count", tx_count - tx0, 1);
    rd_check("rst_mid_timeout", 32'h10, 32'h0000_FFFF);
    rd_check("rst_mid_num_loops", 32'h04, 32'd0);
    rd_check("rst_mid_loop_cnt", 32'h08, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench time limit");
  end
endmodule
